// File: rtl/dsram_responder_pkg.sv
// Shared types and constants for the data SRAM responder.
package dsram_responder_pkg;

  // Responder FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    DSRAM_IDLE = 2'd0,
    DSRAM_WAIT = 2'd1,
    DSRAM_DONE = 2'd2
  } dsram_state_e;

  // Width of the read wait-state down-counter.
  localparam int DSRAM_CNT_W = 4;

  // Values driven onto the pipeline stall request.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Any nonzero byte-enable pattern makes the access a write.
  function automatic logic is_write(input logic [3:0] wen);
    return wen != 4'b0000;
  endfunction

endpackage

// File: rtl/dsram_responder_byte_we_ram.sv
// Single-port word array with per-byte write enables and combinational read.
module byte_we_ram #(
  parameter int IDX_W = 14
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  localparam int DEPTH = 1 << IDX_W;

  logic [31:0] mem [DEPTH];

  // Write each enabled byte lane of the addressed word at the clock edge.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Asynchronous read: sees every write from earlier edges.
  assign rdata = mem[idx];

endmodule

// File: rtl/dsram_responder.sv
// Responder for the core's data SRAM bus: posted byte writes, registered
// read data, and an optional fixed number of read wait states.
//
// Handshake: data_sram_en is the request valid; ~stallreq is the ready.
// A request is consumed on a rising edge where en=1 and stallreq=0 in IDLE.
// Writes are always consumed immediately. A read with wait states raises
// stallreq for WAIT_CYCLES cycles (the requester must hold the request
// stable), then passes through one DONE cycle where the still-present
// request is treated as the same access and not consumed again.
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   data_sram_en,
  input  logic [3:0]             data_sram_wen,
  input  logic [31:0]            data_sram_addr,
  input  logic [31:0]            data_sram_wdata,
  output logic [31:0]            data_sram_rdata,
  output logic                   stallreq,
  output dsram_state_e           dbg_state,
  output logic [DSRAM_CNT_W-1:0] dbg_cnt
);

  localparam int IDX_W = ADDR_W - 2;

  // Counter value loaded when a read enters WAIT (only used for N > 1).
  localparam logic [DSRAM_CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 1) ? DSRAM_CNT_W'(WAIT_CYCLES - 1) : '0;

  dsram_state_e           state_q, state_d;
  logic [DSRAM_CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]       addr_q, addr_d;
  logic [31:0]            rdata_q, rdata_d;

  logic [IDX_W-1:0]       bus_idx;
  logic [IDX_W-1:0]       ram_idx;
  logic [3:0]             ram_we;
  logic [31:0]            ram_rdata;

  // Upper address bits alias and the byte offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W], data_sram_addr[1:0]};
  assign bus_idx          = data_sram_addr[ADDR_W-1:2];

  byte_we_ram #(
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (data_sram_wdata),
    .rdata (ram_rdata)
  );

  // State, counter, latched address and read data registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DSRAM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic, array control and stall request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    ram_we   = 4'b0000;
    ram_idx  = bus_idx;
    stallreq = NO_STOP;

    unique case (state_q)
      DSRAM_IDLE: begin
        if (data_sram_en) begin
          if (is_write(data_sram_wen)) begin
            ram_we = data_sram_wen;
          end else if (WAIT_CYCLES == 0) begin
            rdata_d = ram_rdata;
          end else begin
            stallreq = STOP;
            addr_d   = bus_idx;
            if (WAIT_CYCLES > 1) begin
              state_d = DSRAM_WAIT;
              cnt_d   = CNT_LOAD;
            end else begin
              state_d = DSRAM_DONE;
            end
          end
        end
      end
      DSRAM_WAIT: begin
        stallreq = STOP;
        ram_idx  = addr_q;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == DSRAM_CNT_W'(1)) begin
          state_d = DSRAM_DONE;
        end
      end
      DSRAM_DONE: begin
        ram_idx = addr_q;
        rdata_d = ram_rdata;
        state_d = DSRAM_IDLE;
      end
      default: begin
        state_d = DSRAM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_sram_rdata = rdata_q;
  assign dbg_state       = state_q;
  assign dbg_cnt         = cnt_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench: four responders with different wait-state counts share one
// bus (separate enables), exercised one scenario task at a time.
module tb_dsram_responder;
  import dsram_responder_pkg::*;

  logic         clk = 1'b0;
  logic         rst_all_n;
  logic         rst3_n;
  logic [3:0]   en_v;
  logic [3:0]   wen;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata_v [4];
  logic [3:0]   stall_v;
  dsram_state_e st_v [4];
  logic [3:0]   cnt_v [4];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  dsram_responder #(.ADDR_W(16), .WAIT_CYCLES(0)) u_n0 (
    .clk(clk), .resetn(rst_all_n), .data_sram_en(en_v[0]), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata_v[0]),
    .stallreq(stall_v[0]), .dbg_state(st_v[0]), .dbg_cnt(cnt_v[0]));

  dsram_responder #(.ADDR_W(16), .WAIT_CYCLES(3)) u_n3 (
    .clk(clk), .resetn(rst_all_n), .data_sram_en(en_v[1]), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata_v[1]),
    .stallreq(stall_v[1]), .dbg_state(st_v[1]), .dbg_cnt(cnt_v[1]));

  dsram_responder #(.ADDR_W(16), .WAIT_CYCLES(2)) u_n2 (
    .clk(clk), .resetn(rst_all_n), .data_sram_en(en_v[2]), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata_v[2]),
    .stallreq(stall_v[2]), .dbg_state(st_v[2]), .dbg_cnt(cnt_v[2]));

  dsram_responder #(.ADDR_W(16), .WAIT_CYCLES(4)) u_n4 (
    .clk(clk), .resetn(rst_all_n & rst3_n), .data_sram_en(en_v[3]), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata_v[3]),
    .stallreq(stall_v[3]), .dbg_state(st_v[3]), .dbg_cnt(cnt_v[3]));

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    en_v  = 4'b0000;
    wen   = 4'b0000;
    addr  = 32'h0;
    wdata = 32'h0;
  endtask

  // One write to instance k; a write never stalls.
  task automatic do_write(input int k, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d);
    en_v[k] = 1'b1;
    wen     = w;
    addr    = a;
    wdata   = d;
    #1;
    n_total++;
    if (stall_v[k] !== 1'b0)
      $display("FAIL write_nostall[%0d] a=%h got=%b exp=0", k, a, stall_v[k]);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    idle_bus();
  endtask

  // Zero-wait read on instance 0: data one cycle after the request cycle.
  task automatic do_read0(input logic [31:0] a, input logic [31:0] exp);
    en_v[0] = 1'b1;
    wen     = 4'b0000;
    addr    = a;
    #1;
    n_total++;
    if (stall_v[0] !== 1'b0)
      $display("FAIL read0_nostall a=%h got=%b exp=0", a, stall_v[0]);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    idle_bus();
    #1;
    n_total++;
    if (rdata_v[0] !== exp)
      $display("FAIL read0_data a=%h got=%h exp=%h", a, rdata_v[0], exp);
    else n_pass++;
  endtask

  // Wait-state read on instance k: counts stall cycles, checks DONE cycle,
  // then the data. Leaves the request on the bus at the final IDLE cycle.
  task automatic do_read_wait(input int k, input logic [31:0] a, input int n,
                              input logic [31:0] exp, input logic [31:0] prev,
                              input bit perturb);
    int stalls = 0;
    en_v[k] = 1'b1;
    wen     = 4'b0000;
    addr    = a;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall_v[k] !== 1'b1) break;
      stalls++;
      n_total++;
      if (rdata_v[k] !== prev)
        $display("FAIL wait_hold[%0d] cyc=%0d got=%h exp=%h", k, c, rdata_v[k], prev);
      else n_pass++;
      @(posedge clk); @(negedge clk);
      if (perturb) addr = a + 32'h4;
    end
    n_total++;
    if (stalls != n)
      $display("FAIL stall_len[%0d] a=%h got=%0d exp=%0d", k, a, stalls, n);
    else n_pass++;
    n_total++;
    if (st_v[k] !== DSRAM_DONE)
      $display("FAIL done_state[%0d] got=%0d exp=%0d", k, st_v[k], DSRAM_DONE);
    else n_pass++;
    n_total++;
    if (rdata_v[k] !== prev)
      $display("FAIL done_hold[%0d] got=%h exp=%h", k, rdata_v[k], prev);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    n_total++;
    if (rdata_v[k] !== exp)
      $display("FAIL wait_data[%0d] a=%h got=%h exp=%h", k, a, rdata_v[k], exp);
    else n_pass++;
    n_total++;
    if (st_v[k] !== DSRAM_IDLE)
      $display("FAIL back_idle[%0d] got=%0d exp=%0d", k, st_v[k], DSRAM_IDLE);
    else n_pass++;
  endtask

  // Drop the request and confirm the stall line is low in IDLE.
  task automatic release_bus(input int k);
    idle_bus();
    #1;
    n_total++;
    if (stall_v[k] !== 1'b0)
      $display("FAIL idle_stall[%0d] got=%b exp=0", k, stall_v[k]);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_all_n = 1'b0;
    rst3_n    = 1'b1;
    idle_bus();
    repeat (2) @(negedge clk);
    rst_all_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (rdata_v[k] !== 32'h0 || stall_v[k] !== 1'b0 || st_v[k] !== DSRAM_IDLE
          || cnt_v[k] !== 4'h0)
        $display("FAIL reset[%0d] got rdata=%h stall=%b st=%0d cnt=%0d exp 0/0/0/0",
                 k, rdata_v[k], stall_v[k], st_v[k], cnt_v[k]);
      else n_pass++;
    end
  endtask

  task automatic test_zero_wait();
    do_write(0, 4'b1111, 32'h10, 32'h12345678);
    do_read0(32'h10, 32'h12345678);
    do_write(0, 4'b0101, 32'h10, 32'hAABBCCDD);
    do_read0(32'h10, 32'h12BB56DD);
  endtask

  task automatic test_alias();
    do_write(0, 4'b1111, 32'h0000_0004, 32'h0);
    do_write(0, 4'b0001, 32'h0001_0004, 32'h0000_0055);
    do_read0(32'h0000_0004, 32'h0000_0055);
  endtask

  task automatic test_wait3();
    do_write(1, 4'b1111, 32'h20, 32'hDEADBEEF);
    do_write(1, 4'b1111, 32'h24, 32'h11111111);
    do_read_wait(1, 32'h20, 3, 32'hDEADBEEF, 32'h0, 1'b1);
    release_bus(1);
  endtask

  task automatic test_back_to_back();
    do_write(2, 4'b1111, 32'h0, 32'h1);
    do_write(2, 4'b1111, 32'h4, 32'h2);
    do_read_wait(2, 32'h0, 2, 32'h1, 32'h0, 1'b0);
    do_read_wait(2, 32'h4, 2, 32'h2, 32'h1, 1'b0);
    release_bus(2);
    @(posedge clk); @(negedge clk);
    n_total++;
    if (rdata_v[2] !== 32'h2)
      $display("FAIL b2b_hold got=%h exp=%h", rdata_v[2], 32'h2);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    do_write(3, 4'b1111, 32'h8, 32'hCAFEF00D);
    do_write(3, 4'b1111, 32'hC, 32'h00000077);
    do_read_wait(3, 32'h8, 4, 32'hCAFEF00D, 32'h0, 1'b0);
    // Start a read of 0xC and abort it during the second WAIT cycle.
    addr = 32'hC;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    n_total++;
    if (st_v[3] !== DSRAM_WAIT || cnt_v[3] !== 4'd2 || stall_v[3] !== 1'b1)
      $display("FAIL wait2_state got st=%0d cnt=%0d stall=%b exp 1/2/1",
               st_v[3], cnt_v[3], stall_v[3]);
    else n_pass++;
    idle_bus();
    rst3_n = 1'b0;
    #1;
    n_total++;
    if (stall_v[3] !== 1'b0 || rdata_v[3] !== 32'h0 || st_v[3] !== DSRAM_IDLE
        || cnt_v[3] !== 4'h0)
      $display("FAIL async_reset got stall=%b rdata=%h st=%0d cnt=%0d exp 0/0/0/0",
               stall_v[3], rdata_v[3], st_v[3], cnt_v[3]);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    rst3_n = 1'b1;
    @(negedge clk);
    do_read_wait(3, 32'h8, 4, 32'hCAFEF00D, 32'h0, 1'b0);
    release_bus(3);
    do_read_wait(3, 32'hC, 4, 32'h00000077, 32'hCAFEF00D, 1'b0);
    release_bus(3);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_alias();
    test_wait3();
    test_back_to_back();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
